// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel window scheduling path.
package sobel_pkg;

  localparam int unsigned IMG_W_DEF     = 512;
  localparam int unsigned IMG_H_DEF     = 512;
  localparam int unsigned CW_DEF        = 9;
  localparam int unsigned BORDER_MARGIN = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_WIN,
    PRESENT,
    DONE
  } sched_state_e;

endpackage

// File: rtl/pix_coord_counter.sv
// Raster-order pixel coordinate counter with clear, advance and last-pixel flag.
module pix_coord_counter
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned CW    = CW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [CW-1:0] col_o,
  output logic [CW-1:0] row_o,
  output logic          last_o
);

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_MAX = CW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic          col_end;
  logic          row_end;

  assign col_end = (col_q == COL_MAX);
  assign row_end = (row_q == ROW_MAX);

  // Row wraps explicitly after the last pixel so it never overflows CW bits.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (adv_i) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = col_end & row_end;

endmodule

// File: rtl/sobel_window_sched.sv
// Frame scheduler: one shift per pixel, waits for the window, presents it with valid/ready.
module sobel_window_sched
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned CW    = CW_DEF,
  parameter int unsigned TMO   = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          shift_en,
  input  logic          matrix_finish,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          border,
  output logic          frame_done,
  output logic          busy,
  output logic          err_timeout
);

  localparam int unsigned   TW         = $clog2(TMO + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TMO - 1);
  localparam logic [CW-1:0] COL_BORDER = CW'(BORDER_MARGIN);
  localparam logic [CW-1:0] ROW_BORDER = CW'(IMG_H - BORDER_MARGIN);

  sched_state_e  state_q;
  logic [TW-1:0] tmo_q;
  logic          shift_en_q;
  logic          win_valid_q;
  logic          frame_done_q;
  logic          busy_q;
  logic          err_q;

  logic          abort_act;
  logic          accept;
  logic          coord_clr;
  logic          coord_adv;
  logic          last_pix;

  assign abort_act = abort && (state_q != IDLE);
  assign accept    = (state_q == PRESENT) && win_valid_q && win_ready;
  assign coord_adv = accept && !abort_act;
  assign coord_clr = abort_act
                   || ((state_q == IDLE) && start && !abort)
                   || (state_q == DONE);

  pix_coord_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CW    (CW)
  ) u_coord (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (coord_clr),
    .adv_i  (coord_adv),
    .col_o  (col),
    .row_o  (row),
    .last_o (last_pix)
  );

  // Outputs are registered alongside the state, so each reflects the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      shift_en_q   <= 1'b0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      shift_en_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (abort_act) begin
        state_q     <= IDLE;
        tmo_q       <= '0;
        win_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              state_q    <= ISSUE;
              shift_en_q <= 1'b1;
              busy_q     <= 1'b1;
              err_q      <= 1'b0;
            end
          end
          ISSUE: begin
            tmo_q   <= '0;
            state_q <= WAIT_WIN;
          end
          WAIT_WIN: begin
            // Timeout wins over a window arriving in the final allowed cycle.
            if (tmo_q == TMO_LAST) begin
              state_q <= IDLE;
              tmo_q   <= '0;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else if (matrix_finish) begin
              state_q     <= PRESENT;
              win_valid_q <= 1'b1;
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end
          PRESENT: begin
            if (win_ready) begin
              win_valid_q <= 1'b0;
              if (last_pix) begin
                state_q      <= DONE;
                frame_done_q <= 1'b1;
              end else begin
                state_q    <= ISSUE;
                shift_en_q <= 1'b1;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q     <= IDLE;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign shift_en    = shift_en_q;
  assign win_valid   = win_valid_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
  assign border      = (col < COL_BORDER) | (row >= ROW_BORDER);

endmodule

// File: tb/tb_sobel_window_sched.sv
// Scoreboard bench for sobel_window_sched on a 4x3 image with a 5-cycle generator model.
module tb_sobel_window_sched;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int CW  = 9;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          matrix_finish = 1'b0;
  logic          win_ready = 1'b0;
  logic          shift_en, win_valid, border, frame_done, busy, err_timeout;
  logic [CW-1:0] col, row;

  always #5 clk = ~clk;

  sobel_window_sched #(
    .IMG_W (W),
    .IMG_H (H),
    .CW    (CW),
    .TMO   (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .shift_en      (shift_en),
    .matrix_finish (matrix_finish),
    .win_valid     (win_valid),
    .win_ready     (win_ready),
    .col           (col),
    .row           (row),
    .border        (border),
    .frame_done    (frame_done),
    .busy          (busy),
    .err_timeout   (err_timeout)
  );

  typedef struct {
    int c;
    int r;
    int b;
  } win_t;

  win_t exp_q[$];
  // Hand-derived border flags in raster order: col<2 or row>=1.
  int   btab[12] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sh_cnt = 0;
  int fd_cnt = 0;
  int last_acc = -100;
  int gen_cnt = 0;
  bit gen_mute = 1'b0;

  function automatic void chk(string nm, int got, int exp_v);
    checks++;
    if (got != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp_v, cyc);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Generator model: matrix_finish sampled by the DUT 5 edges after it sees shift_en.
  always @(posedge clk) begin
    if (rst || abort || gen_mute) gen_cnt = 0;
    else if (shift_en) gen_cnt = 5;
    else if (gen_cnt > 0) gen_cnt--;
    #1 matrix_finish = (gen_cnt == 1);
  end

  // Monitor: pops the scoreboard on every accepted window.
  always @(negedge clk) begin
    if (!rst) begin
      if (shift_en) sh_cnt++;
      if (frame_done) begin
        fd_cnt++;
        chk("frame_done_latency", cyc - last_acc, 1);
      end
      if (win_valid && win_ready) begin
        last_acc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_accept: got window (%0d,%0d) expected none", col, row);
        end else begin
          win_t e;
          e = exp_q.pop_front();
          chk("win_col", int'(col), e.c);
          chk("win_row", int'(row), e.r);
          chk("win_border", int'(border), e.b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int n);
    for (int i = 0; i < n; i++) begin
      win_t e;
      e.c = i % W;
      e.r = i / W;
      e.b = btab[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_to_shift_en", int'(shift_en), 1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 200; i++) begin
      if (win_valid) break;
      tick();
    end
    chk("win_valid_wait", int'(win_valid), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000; i++) begin
      if (!busy) break;
      tick();
    end
    chk("busy_wait", int'(busy), 0);
  endtask

  task automatic accept_one();
    win_ready = 1'b1;
    tick();
    win_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_shift_en"}, int'(shift_en), 0);
    chk({tag, "_win_valid"}, int'(win_valid), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_err"}, int'(err_timeout), 0);
    chk({tag, "_col"}, int'(col), 0);
    chk({tag, "_row"}, int'(row), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sh_before;

    // Power-on reset
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("por");

    // Reset asserted mid-frame while a window is being presented
    win_ready = 1'b0;
    pulse_start();
    repeat (12) tick();
    chk("pre_reset_valid", int'(win_valid), 1);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("midrst");
    chk("midrst_border", int'(border), 1);

    // Full frame with win_ready held high
    sh_cnt = 0;
    fd_cnt = 0;
    push_frame(12);
    win_ready = 1'b1;
    pulse_start();
    wait_idle();
    win_ready = 1'b0;
    repeat (2) tick();
    chk("full_shift_count", sh_cnt, 12);
    chk("full_frame_done_count", fd_cnt, 1);
    chk("full_sb_empty", exp_q.size(), 0);

    // Backpressure on window 5 at (0,1)
    sh_cnt = 0;
    fd_cnt = 0;
    push_frame(12);
    pulse_start();
    for (int w = 0; w < 12; w++) begin
      wait_valid();
      if (w == 4) begin
        sh_before = sh_cnt;
        repeat (10) begin
          @(negedge clk);
          chk("stall_valid", int'(win_valid), 1);
          chk("stall_col", int'(col), 0);
          chk("stall_row", int'(row), 1);
        end
        chk("stall_no_shift", sh_cnt, sh_before);
        tick();
      end
      accept_one();
    end
    wait_idle();
    repeat (2) tick();
    chk("bp_shift_count", sh_cnt, 12);
    chk("bp_frame_done_count", fd_cnt, 1);

    // Timeout: generator never answers
    gen_mute = 1'b1;
    fd_cnt = 0;
    pulse_start();
    repeat (15) tick();
    chk("tmo_err_before", int'(err_timeout), 0);
    chk("tmo_busy_before", int'(busy), 1);
    tick();
    chk("tmo_err_set", int'(err_timeout), 1);
    chk("tmo_busy_clear", int'(busy), 0);
    repeat (3) tick();
    chk("tmo_err_sticky", int'(err_timeout), 1);
    chk("tmo_no_frame_done", fd_cnt, 0);
    gen_mute = 1'b0;

    // Start clears the error; abort while window 7 at (2,1) is presented
    push_frame(6);
    pulse_start();
    chk("err_cleared_by_start", int'(err_timeout), 0);
    for (int w = 0; w < 6; w++) begin
      wait_valid();
      accept_one();
    end
    wait_valid();
    chk("pre_abort_col", int'(col), 2);
    chk("pre_abort_row", int'(row), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_win_valid", int'(win_valid), 0);
    chk("abort_shift_en", int'(shift_en), 0);
    repeat (3) tick();
    chk("abort_no_frame_done", fd_cnt, 0);
    chk("abort_sb_empty", exp_q.size(), 0);

    // New frame after abort restarts at (0,0); stray start mid-frame is ignored
    sh_cnt = 0;
    fd_cnt = 0;
    push_frame(12);
    win_ready = 1'b1;
    pulse_start();
    chk("restart_col", int'(col), 0);
    chk("restart_row", int'(row), 0);
    repeat (20) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
    win_ready = 1'b0;
    repeat (2) tick();
    chk("busy_start_shift_count", sh_cnt, 12);
    chk("busy_start_frame_done_count", fd_cnt, 1);

    // start together with abort in IDLE
    sh_cnt = 0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("startabort_busy", int'(busy), 0);
    chk("startabort_shift_en", int'(shift_en), 0);
    repeat (5) tick();
    chk("startabort_no_shift", sh_cnt, 0);
    chk("startabort_idle", int'(busy), 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_window_sched.md
Name: sobel_window_sched

Overview:
- Frame-level scheduler for the Sobel 3x3 window generator.
- Issues one shift_en per pixel and waits for that window's matrix_finish.
- Presents each window to the downstream Sobel/UART path with a valid/ready handshake, and tracks the pixel coordinate and border status.
- Sits between the top-level start/control logic and matrix_generate_3x3; exactly one shift is outstanding at any time.

Parameters:
- IMG_W, 512, image width in pixels
- IMG_H, 512, image height in pixels
- CW, 9, coordinate width; must satisfy 2**CW >= max(IMG_W, IMG_H)
- TMO, 15, maximum cycles in WAIT_WIN before timeout

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  frame start request, sampled in IDLE only
- abort  in  1  terminates the frame immediately
- shift_en  out  1  one-cycle pulse to the window generator
- matrix_finish  in  1  generator pulse: window registers updated
- win_valid  out  1  window for (col,row) available to downstream
- win_ready  in  1  downstream accepts the window
- col  out  CW  column index of the newest window column (p13)
- row  out  CW  top row index of the window (p11 row)
- border  out  1  window incomplete or off-image; downstream forces result to 0
- frame_done  out  1  one-cycle pulse after the last window is accepted
- busy  out  1  high in every state except IDLE
- err_timeout  out  1  sticky timeout flag, cleared by rst or an accepted start

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, col=row=0.
  - shift_en, win_valid, frame_done, busy, err_timeout all 0.
  - Timeout counter 0.
- States: IDLE, ISSUE, WAIT_WIN, PRESENT, DONE.
- IDLE:
  - start=1 -> ISSUE next cycle; col=row=0; err_timeout cleared.
- ISSUE:
  - shift_en=1 for exactly this cycle; timeout counter cleared; -> WAIT_WIN.
- WAIT_WIN:
  - Timeout counter increments each cycle.
  - matrix_finish=1 -> PRESENT. win_valid rises on the next edge (registered output).
  - Counter reaching TMO with no matrix_finish -> err_timeout=1, -> IDLE, no frame_done.
  - matrix_finish arriving outside WAIT_WIN is ignored.
- PRESENT:
  - win_valid held at 1; col, row and border held stable until win_ready=1.
  - On accept (win_valid & win_ready):
    - win_valid drops next cycle.
    - Coordinate advances: col+1; at col=IMG_W-1, col=0 and row+1.
    - Last pixel (col=IMG_W-1, row=IMG_H-1) -> DONE; otherwise -> ISSUE.
- DONE:
  - frame_done=1 for one cycle; coordinates reset to 0; -> IDLE.
- Abort:
  - abort=1 in any non-IDLE state -> IDLE on the next edge; shift_en and win_valid deassert; counters cleared; no frame_done.
  - Generator state is not restored. The top level resets the generator before the next start.
- Precedence on the same edge: rst > abort > timeout > handshake. start together with abort in IDLE -> stays IDLE.
- start while busy: ignored.
- border = (col < 2) | (row >= IMG_H-2). This is combinational from the registered col/row and covers generator warm-up columns and zero-filled rows past the image end.
- Throughput: minimum ISSUE->PRESENT spacing equals generator latency (≥3 cycles, matching its 3-phase row read). The scheduler never issues a second shift before acceptance.
- Latency: start -> shift_en = 1 cycle. Accept -> next shift_en = 1 cycle. Last accept -> frame_done = 1 cycle.
- Widths: col/row wrap only via the explicit compares above, never by overflow. Timeout counter width is clog2(TMO+1).

Decomposition:
- Package sobel_pkg holds:
  - state enum (IDLE, ISSUE, WAIT_WIN, PRESENT, DONE)
  - IMG_W/IMG_H defaults and CW
  - border-margin constant (2)
- One sub-module: pix_coord_counter (col/row counter with advance, clear and last-pixel flag). Reused later by the frame writer.

Test Plan:
- Reset: rst=1 for 3 cycles mid-frame -> next cycle all outputs 0, busy=0, col=row=0.
- Full frame, IMG_W=4, IMG_H=3; generator model returns matrix_finish 5 cycles after shift_en; win_ready=1 -> exactly 12 shift_en pulses.
  - (col,row) runs (0,0)..(3,2) in raster order.
  - border=1 for col<2 or row>=1.
  - Single frame_done 1 cycle after the 12th accept.
- Backpressure: win_ready held 0 for 10 cycles at window 5 -> win_valid stays 1, col/row stable at (0,1), no shift_en; accept resumes at (1,1).
- Timeout: generator never answers the first shift_en -> err_timeout=1 after 15 cycles in WAIT_WIN, busy=0, frame_done never asserted. A subsequent start clears err_timeout.
- Abort: abort at window 6 -> next cycle busy=0, win_valid=0, no frame_done. A new start yields first window at (0,0).
- Collisions: start while busy ignored (no restart, coordinates continue). start+abort together in IDLE -> remains IDLE, no shift_en.
